// File: rtl/bram_rd_fifo.sv
// rtl/bram_rd_fifo.sv - counted read-data capture FIFO behind a BRAM read controller
module bram_rd_fifo #(
   parameter int DWIDTH    = 16,
   parameter int AWIDTH    = 7,
   parameter int FIFO_LOG2 = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_run,
   input  logic [AWIDTH-1:0]    i_num_cnt,
   output logic                 o_idle,
   output logic                 o_running,
   output logic                 o_done,
   input  logic                 i_valid,
   input  logic [DWIDTH-1:0]    i_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [DWIDTH-1:0]    m_data,
   output logic [FIFO_LOG2:0]   o_level,
   output logic                 o_overflow
);

   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam int LW    = FIFO_LOG2 + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state;
   logic [AWIDTH-1:0]    num_cnt;
   logic [AWIDTH-1:0]    in_cnt;
   logic [AWIDTH-1:0]    out_cnt;
   logic [AWIDTH-1:0]    drop_cnt;
   logic [FIFO_LOG2-1:0] wr_ptr;
   logic [FIFO_LOG2-1:0] rd_ptr;
   logic [LW-1:0]        level;
   logic                 overflow;

   logic [DWIDTH-1:0]    mem [DEPTH];

   logic                 full;
   logic                 pop;
   logic                 push_try;
   logic                 push_ok;
   logic                 drop;
   logic [AWIDTH-1:0]    out_cnt_nxt;
   logic [AWIDTH-1:0]    drop_cnt_nxt;
   logic [LW-1:0]        level_nxt;
   logic                 fin;

   // Push/pop qualification and the completion test on post-edge counter values
   always_comb begin
      full         = (level == LW'(DEPTH));
      pop          = (level != '0) && m_ready;
      push_try     = (state == S_RUN) && i_valid && (in_cnt < num_cnt);
      push_ok      = push_try && (!full || pop);
      drop         = push_try && full && !pop;
      out_cnt_nxt  = out_cnt + AWIDTH'(pop);
      drop_cnt_nxt = drop_cnt + AWIDTH'(drop);
      fin          = ({1'b0, out_cnt_nxt} + {1'b0, drop_cnt_nxt}) == {1'b0, num_cnt};
      level_nxt    = level;
      case ({push_ok, pop})
         2'b10:   level_nxt = level + LW'(1);
         2'b01:   level_nxt = level - LW'(1);
         default: level_nxt = level;
      endcase
   end

   // Control FSM plus pointer, level and counter bookkeeping; i_run restarts everything
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         num_cnt  <= '0;
         in_cnt   <= '0;
         out_cnt  <= '0;
         drop_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok)  wr_ptr <= wr_ptr + FIFO_LOG2'(1);
         if (pop)      rd_ptr <= rd_ptr + FIFO_LOG2'(1);
         if (push_try) in_cnt <= in_cnt + AWIDTH'(1);
         if (drop)     overflow <= 1'b1;
         out_cnt  <= out_cnt_nxt;
         drop_cnt <= drop_cnt_nxt;
         level    <= level_nxt;
         case (state)
            S_IDLE: begin
               if (i_run) begin
                  state    <= S_RUN;
                  num_cnt  <= i_num_cnt;
                  in_cnt   <= '0;
                  out_cnt  <= '0;
                  drop_cnt <= '0;
                  wr_ptr   <= '0;
                  rd_ptr   <= '0;
                  level    <= '0;
                  overflow <= 1'b0;
               end
            end
            S_RUN: begin
               if (fin) state <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Storage write; contents are meaningless until pushed, so no reset
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= i_data;
   end

   assign m_valid    = (level != '0);
   assign m_data     = mem[rd_ptr];
   assign o_level    = level;
   assign o_overflow = overflow;
   assign o_idle     = (state == S_IDLE);
   assign o_running  = (state == S_RUN);
   assign o_done     = (state == S_DONE);

endmodule
